// File: rtl/conv2d_stream_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine_pkg
// Description : Shared types and helpers for the conv2d stream engine:
//               controller state encoding, output-side formula and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_stream_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_F = 3'd1,
    S_LOAD_A = 3'd2,
    S_MAC    = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Output side of a convolution over a zero-padded square tile.
  function automatic int calc_os(input int as, input int fs, input int str, input int zp);
    return (as + 2 * zp - fs) / str + 1;
  endfunction

  // Bits needed to index n entries (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine_if
// Description : Generic valid/ready stream of W-bit data. Used for the
//               weight, activation and result streams of the engine.
//   valid : producer has data
//   data  : payload, W bits
//   ready : consumer accepts; a beat is a cycle with valid & ready
// Revision    : 1.0 - initial release
// ============================================================================
interface conv2d_stream_engine_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/conv2d_stream_engine_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine_mac
// Description : Two-stage signed multiply-accumulate (conv_mac).
//               Stage 1 registers a*w; stage 2 sign-extends the product and
//               either loads it (first term) or adds it to the accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   en       : a term is presented this cycle
//   clr      : this term is the first of a new sum
//   last     : this term is the final one of the sum
//   a, w     : signed operands
//   acc      : accumulator
//   acc_done : one-cycle pulse when the final term has been accumulated
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream_engine_mac #(
  parameter int DW = 8,
  parameter int WW = 9,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [WW-1:0] w,
  output logic signed [AW-1:0] acc,
  output logic                 acc_done
);
  localparam int PW = DW + WW;

  logic signed [PW-1:0] r_prod;
  logic                 r_pv;
  logic                 r_pclr;
  logic                 r_plast;
  logic signed [AW-1:0] r_acc;
  logic                 r_acc_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod     <= '0;
      r_pv       <= 1'b0;
      r_pclr     <= 1'b0;
      r_plast    <= 1'b0;
      r_acc      <= '0;
      r_acc_done <= 1'b0;
    end else begin
      r_pv       <= en;
      r_pclr     <= en && clr;
      r_plast    <= en && last;
      if (en) begin
        r_prod <= PW'(a) * PW'(w);
      end
      if (r_pv) begin
        r_acc <= r_pclr ? AW'(r_prod) : r_acc + AW'(r_prod);
      end
      r_acc_done <= r_pv && r_plast;
    end
  end

  assign acc      = r_acc;
  assign acc_done = r_acc_done;
endmodule
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream_engine
// Description : Self-sequenced 2-D convolution engine. Loads FS*FS weights,
//               then an AS*AS activation tile, then streams OS*OS results,
//               one multiply per cycle per result, with optional ReLU.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a job (ignored unless idle); relu_en sampled with it
//   f_s      : weight stream in, raster order (ready only while loading)
//   a_s      : activation stream in, raster order (ready only while loading)
//   o_m      : result stream out, raster order, held under backpressure
//   busy     : high in every state except idle
//   done     : one-cycle pulse after the last result is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream_engine
  import conv2d_stream_engine_pkg::*;
#(
  parameter int DW  = 8,
  parameter int WW  = 9,
  parameter int AW  = 20,
  parameter int AS  = 6,
  parameter int FS  = 3,
  parameter int STR = 1,
  parameter int ZP  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    relu_en,
  conv2d_stream_engine_if.slave   f_s,
  conv2d_stream_engine_if.slave   a_s,
  conv2d_stream_engine_if.master  o_m,
  output logic                    busy,
  output logic                    done
);
  localparam int OS  = calc_os(AS, FS, STR, ZP);
  localparam int NF  = FS * FS;
  localparam int NA  = AS * AS;
  localparam int FIW = cnt_w(NF);
  localparam int AIW = cnt_w(NA);
  localparam int LDW = cnt_w((NA > NF) ? NA : NF);
  localparam int KW  = cnt_w(FS);
  localparam int OW  = cnt_w(OS);

  state_t               r_state;
  logic [LDW-1:0]       r_ld;
  logic [KW-1:0]        r_kr, r_kc;
  logic [OW-1:0]        r_orow, r_ocol;
  logic signed [WW-1:0] r_fbuf [NF];
  logic signed [DW-1:0] r_abuf [NA];
  logic                 r_relu, r_f_ready, r_a_ready, r_out_valid, r_busy, r_done;
  logic signed [AW-1:0] r_out_data;

  int                   w_pr, w_pc, w_idx;
  logic                 w_in;
  logic [AIW-1:0]       w_aidx;
  logic [FIW-1:0]       w_fidx;
  logic signed [DW-1:0] w_a_op;
  logic signed [WW-1:0] w_w_op;
  logic                 w_first, w_last;
  logic signed [AW-1:0] w_acc;
  logic                 w_acc_done;

  // Padded coordinates of the current tap. Pad cells are never stored, so a
  // coordinate outside the real tile yields a zero operand and no buffer read.
  always_comb begin
    w_pr   = int'(r_orow) * STR + int'(r_kr);
    w_pc   = int'(r_ocol) * STR + int'(r_kc);
    w_in   = (w_pr >= ZP) && (w_pr < ZP + AS) && (w_pc >= ZP) && (w_pc < ZP + AS);
    w_idx  = w_in ? ((w_pr - ZP) * AS + (w_pc - ZP)) : 0;
    w_aidx = AIW'(w_idx);
    w_fidx = FIW'(int'(r_kr) * FS + int'(r_kc));
    w_a_op = w_in ? r_abuf[w_aidx] : '0;
    w_w_op = r_fbuf[w_fidx];
  end

  assign w_first = (r_kr == '0) && (r_kc == '0);
  assign w_last  = (r_kr == KW'(FS - 1)) && (r_kc == KW'(FS - 1));

  conv2d_stream_engine_mac #(
    .DW (DW),
    .WW (WW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (r_state == S_MAC),
    .clr      (w_first),
    .last     (w_last),
    .a        (w_a_op),
    .w        (w_w_op),
    .acc      (w_acc),
    .acc_done (w_acc_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ld        <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_orow      <= '0;
      r_ocol      <= '0;
      r_relu      <= 1'b0;
      r_f_ready   <= 1'b0;
      r_a_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < NF; i++) r_fbuf[i] <= '0;
      for (int i = 0; i < NA; i++) r_abuf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_relu    <= relu_en;
            r_busy    <= 1'b1;
            r_f_ready <= 1'b1;
            r_ld      <= '0;
            r_state   <= S_LOAD_F;
          end
        end
        S_LOAD_F: begin
          if (f_s.valid && r_f_ready) begin
            r_fbuf[FIW'(r_ld)] <= f_s.data;
            if (r_ld == LDW'(NF - 1)) begin
              r_ld      <= '0;
              r_f_ready <= 1'b0;
              r_a_ready <= 1'b1;
              r_state   <= S_LOAD_A;
            end else begin
              r_ld <= r_ld + 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          if (a_s.valid && r_a_ready) begin
            r_abuf[AIW'(r_ld)] <= a_s.data;
            if (r_ld == LDW'(NA - 1)) begin
              r_ld      <= '0;
              r_a_ready <= 1'b0;
              r_kr      <= '0;
              r_kc      <= '0;
              r_orow    <= '0;
              r_ocol    <= '0;
              r_state   <= S_MAC;
            end else begin
              r_ld <= r_ld + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (w_last) begin
            r_kr    <= '0;
            r_kc    <= '0;
            r_state <= S_EMIT;
          end else if (r_kc == KW'(FS - 1)) begin
            r_kc <= '0;
            r_kr <= r_kr + 1'b1;
          end else begin
            r_kc <= r_kc + 1'b1;
          end
        end
        S_EMIT: begin
          // Wait for the last term to drain through the MAC pipeline, then
          // hold the result until it is accepted.
          if (w_acc_done) begin
            r_out_data  <= (r_relu && w_acc[AW-1]) ? '0 : w_acc;
            r_out_valid <= 1'b1;
          end else if (r_out_valid && o_m.ready) begin
            r_out_valid <= 1'b0;
            if (r_orow == OW'(OS - 1) && r_ocol == OW'(OS - 1)) begin
              r_orow  <= '0;
              r_ocol  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              if (r_ocol == OW'(OS - 1)) begin
                r_ocol <= '0;
                r_orow <= r_orow + 1'b1;
              end else begin
                r_ocol <= r_ocol + 1'b1;
              end
              r_state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign f_s.ready = r_f_ready;
  assign a_s.ready = r_a_ready;
  assign o_m.valid = r_out_valid;
  assign o_m.data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_stream_engine
// Description : Self-checking bench. Two engines share all input streams:
//               a default build (ZP=0, STR=1) and a padded/strided build
//               (ZP=1, STR=2). Results are compared against a padded-image
//               convolution model computed with plain loops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream_engine;
  localparam int DW = 8, WW = 9, AW = 20, AS = 6, FS = 3, NF = FS * FS, NA = AS * AS;

  logic clk, rst, start, relu_en, out_ready;
  logic busy0, busy1, done0, done1;

  conv2d_stream_engine_if #(.W(WW)) f0 ();
  conv2d_stream_engine_if #(.W(WW)) f1 ();
  conv2d_stream_engine_if #(.W(DW)) a0 ();
  conv2d_stream_engine_if #(.W(DW)) a1 ();
  conv2d_stream_engine_if #(.W(AW)) o0 ();
  conv2d_stream_engine_if #(.W(AW)) o1 ();

  assign f1.valid = f0.valid;
  assign f1.data  = f0.data;
  assign a1.valid = a0.valid;
  assign a1.data  = a0.data;
  assign o0.ready = out_ready;
  assign o1.ready = out_ready;

  conv2d_stream_engine #(.DW(DW), .WW(WW), .AW(AW), .AS(AS), .FS(FS), .STR(1), .ZP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .f_s(f0), .a_s(a0), .o_m(o0), .busy(busy0), .done(done0));

  conv2d_stream_engine #(.DW(DW), .WW(WW), .AW(AW), .AS(AS), .FS(FS), .STR(2), .ZP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .f_s(f1), .a_s(a1), .o_m(o1), .busy(busy1), .done(done1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_chk = 0, n_err = 0;
  int     act [AS][AS];
  int     flt [FS][FS];
  longint exp0[$], exp1[$], rx0[$], rx1[$];
  int     n_done0, n_done1, rdy_mode, stall_n;
  bit     hold_pend = 1'b0;
  longint hold_val;

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: build the zero-padded image explicitly, then slide the filter.
  function automatic void model(input int zp, input int str, input bit relu, output longint q[$]);
    longint pad [AS+2][AS+2];
    longint s;
    int     os;
    q  = {};
    os = (AS + 2 * zp - FS) / str + 1;
    for (int r = 0; r < AS + 2; r++)
      for (int c = 0; c < AS + 2; c++) pad[r][c] = 0;
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) pad[r+zp][c+zp] = act[r][c];
    for (int orow = 0; orow < os; orow++)
      for (int ocol = 0; ocol < os; ocol++) begin
        s = 0;
        for (int kr = 0; kr < FS; kr++)
          for (int kc = 0; kc < FS; kc++)
            s += pad[orow*str+kr][ocol*str+kc] * flt[kr][kc];
        if (relu && s < 0) s = 0;
        q.push_back(s);
      end
  endfunction

  // Collect accepted results, count done pulses, and check held outputs.
  always @(negedge clk) begin
    if (o0.valid && out_ready) rx0.push_back(longint'($signed(o0.data)));
    if (o1.valid && out_ready) rx1.push_back(longint'($signed(o1.data)));
    if (done0) n_done0++;
    if (done1) n_done1++;
    if (hold_pend && !rst) begin
      check_val("hold_valid", longint'(o0.valid), 1);
      check_val("hold_data", longint'($signed(o0.data)), hold_val);
    end
    hold_pend = o0.valid && !out_ready;
    hold_val  = longint'($signed(o0.data));
  end

  // Output-ready driver: 0 = always ready, 1 = random, 2 = five-cycle stall
  // while the fourth result is pending.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (o0.valid && rx0.size() == 3 && stall_n < 5) begin
            out_ready = 1'b0;
            stall_n++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic run_job(input bit relu, input bit gaps, input int rmode,
                         input bit start_spam, input bit abort);
    int i, cyc, n;
    bit seen;
    model(0, 1, relu, exp0);
    model(1, 2, relu, exp1);
    rx0 = {}; rx1 = {};
    n_done0 = 0; n_done1 = 0; stall_n = 0; rdy_mode = rmode;
    @(posedge clk); #1;
    relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; relu_en = 1'b0;
    i = 0; cyc = 0;
    while (i < NF && cyc < 1000) begin
      f0.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      f0.data  = WW'(flt[i / FS][i % FS]);
      @(negedge clk);
      if (f0.valid && f0.ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    f0.valid = 1'b0;
    check_val("f_beats", i, NF);
    i = 0; cyc = 0;
    while (i < NA && cyc < 2000) begin
      a0.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a0.data  = DW'(act[i / AS][i % AS]);
      start    = start_spam && (i % 7 == 3);
      @(negedge clk);
      if (a0.valid && a0.ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    a0.valid = 1'b0;
    start    = 1'b0;
    check_val("a_beats", i, NA);
    if (abort) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_val("abort_busy", longint'(busy0), 0);
      check_val("abort_valid", longint'(o0.valid), 0);
      check_val("abort_data", longint'(o0.data), 0);
      check_val("abort_done", longint'(done0), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      check_val("abort_no_out", rx0.size() + rx1.size(), 0);
      check_val("abort_idle", longint'(busy0), 0);
      return;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (o0.valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_val("latency", n, NF + 2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((busy0 || busy1) && cyc < 5000);
    check_val("job_timeout", longint'(cyc < 5000), 1);
    check_val("n_out0", rx0.size(), exp0.size());
    check_val("n_out1", rx1.size(), exp1.size());
    for (int k = 0; k < exp0.size() && k < rx0.size(); k++)
      check_val($sformatf("out0[%0d]", k), rx0[k], exp0[k]);
    for (int k = 0; k < exp1.size() && k < rx1.size(); k++)
      check_val($sformatf("out1[%0d]", k), rx1[k], exp1[k]);
    check_val("done0_once", n_done0, 1);
    check_val("done1_once", n_done1, 1);
  endtask

  task automatic set_ramp_act();
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) act[r][c] = 6 * r + c;
  endtask

  task automatic set_flt(input int v);
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < FS; c++) flt[r][c] = v;
  endtask

  task automatic set_random();
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) act[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < FS; c++) flt[r][c] = int'($urandom_range(0, 511)) - 256;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; rdy_mode = 0;
    f0.valid = 1'b0; f0.data = '0; a0.valid = 1'b0; a0.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", longint'(busy0), 0);
    check_val("rst_done", longint'(done0), 0);
    check_val("rst_valid", longint'(o0.valid), 0);
    check_val("rst_data", longint'(o0.data), 0);
    check_val("rst_f_ready", longint'(f0.ready), 0);
    check_val("rst_a_ready", longint'(a0.ready), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Ramp tile, all-ones filter.
    set_ramp_act(); set_flt(1);
    run_job(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_val("t1_out00", rx0[0], 63);
    check_val("t1_out01", rx0[1], 72);
    check_val("t1_out10", rx0[4], 117);
    check_val("t1_out33", rx0[15], 252);

    // Negative filter, without and with ReLU.
    set_flt(-1);
    run_job(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_val("t2_out00", rx0[0], -63);
    run_job(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_val("t2_relu00", rx0[0], 0);

    // Largest-magnitude product sum.
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) act[r][c] = -128;
    set_flt(-256);
    run_job(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_val("t3_out", rx0[5], 294912);

    // Random data with input gaps and output backpressure.
    set_random();
    run_job(1'b0, 1'b1, 2, 1'b0, 1'b0);
    set_random();
    run_job(1'b1, 1'b1, 1, 1'b0, 1'b0);

    // Abort during MAC, then a fresh job with spurious start pulses.
    set_ramp_act(); set_flt(1);
    run_job(1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_job(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check_val("t6_out00", rx0[0], 63);
    check_val("t6_out33", rx0[15], 252);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
